kernel_cc_start_arbiter: RTL and testbench
==========================================

Name: kernel_cc_start_arbiter

Overview:
Round-robin scheduler that shares one start-token FIFO (shift-register start FIFO, 1-deep write handshake) between NUM_REQ producer processes of the connected-components dataflow kernel.
Grants one requester per cycle, pushes the winner's ID as the FIFO token, and throttles on FIFO full and on in-flight tokens not yet retired by the write-back consumer.
Supports a graceful drain when disabled.

Parameters:
NUM_REQ, 4, number of requesting processes
ID_WIDTH, 2, width of requester ID token (ceil(log2(NUM_REQ)), min 1)
MAX_OUTSTANDING, 4, max tokens pushed but not yet retired by wb_done
CNT_WIDTH, 3, width of outstanding counter (must hold MAX_OUTSTANDING)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  level; 1 = arbitration allowed, 0 = stop granting and drain
req_start  input  NUM_REQ  per-requester start request, level, held until acked
req_ack  output  NUM_REQ  one-hot grant; the request is consumed at this clock edge
fifo_full_n  input  1  start FIFO not full
fifo_write  output  1  push strobe to start FIFO
fifo_write_ce  output  1  FIFO write clock-enable, constant 1 after reset
fifo_din  output  ID_WIDTH  token = ID of the granted requester
wb_done  input  1  one-cycle pulse, consumer finished one token
outstanding  output  CNT_WIDTH  registered count of in-flight tokens
idle  output  1  1 when in IDLE state
err  output  1  sticky: wb_done received with outstanding == 0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - State = IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - outstanding = 0; err = 0; idle = 1.
  - req_ack = 0; fifo_write = 0; fifo_din = 0.
  - fifo_write_ce = 1.
- States:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> DRAIN.
  - DRAIN:
    - outstanding==0 and enable=0 -> IDLE.
    - enable=1 -> RUN (re-enable aborts the drain).
- Grant condition (combinational, RUN only): can_grant = fifo_full_n & (outstanding < MAX_OUTSTANDING) & |req_start.
- Arbitration:
  - Winner = first asserted req_start scanning from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - When can_grant, in the same cycle: req_ack[winner]=1, fifo_write=1, fifo_din=winner.
  - Otherwise all three are 0 (fifo_din=0).
- Zero-latency handshake:
  - Request sampled and acked in the same cycle.
  - At most one grant per cycle, so sustained throughput is 1 token/cycle.
- On a grant edge: rr_ptr <= winner.
- rr_ptr is unchanged when there is no grant.
- outstanding update:
  - +1 on grant only; -1 on wb_done only.
  - Grant and wb_done in the same cycle: unchanged.
  - wb_done with outstanding==0: counter stays 0 and err <= 1.
  - err is cleared only by reset.
- Boundaries:
  - outstanding==MAX_OUTSTANDING blocks grants. A wb_done in that cycle does NOT enable a same-cycle grant; the grant occurs the next cycle.
  - fifo_full_n=0 blocks grants; requests stay pending.
  - No grants in IDLE or DRAIN. wb_done is still counted in all states.
  - Requester deasserting req_start before its ack: dropped, no token.
  - Reset mid-operation: all state returns to reset values next edge; tokens already in the FIFO are not tracked (the FIFO shares the same reset).
- Outputs req_ack, fifo_write and fifo_din are combinational from state/registers and inputs. There is no combinational path from wb_done to the grant outputs.

Decomposition:
- Shared package kernel_cc_sched_pkg:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
  - Default NUM_REQ, ID_WIDTH and MAX_OUTSTANDING.
- One sub-module: kernel_cc_rr_pick.
  - Purely combinational: inputs req vector and rr_ptr; outputs winner ID, one-hot vector and any-valid.
  - Reusable by other schedulers in the kernel.

Test Plan:
1. Reset, enable=1, req_start=4'b1111, fifo_full_n=1, wb_done pulsed each cycle from cycle 2 -> acks cycle through 0,1,2,3,0 on consecutive cycles; fifo_din matches; outstanding stays <=1.
2. req_start=4'b0101 held, no wb_done, MAX_OUTSTANDING=4 -> grants 0,2,0,2 then stall; outstanding=4. Then one wb_done -> exactly one grant (ID 0) on the following cycle.
3. fifo_full_n=0 for 3 cycles with req_start=4'b0010 -> no fifo_write, no ack. fifo_full_n=1 -> ack[1] and fifo_din=1 the same cycle.
4. Simultaneous grant and wb_done with outstanding=2 -> outstanding stays 2. wb_done with outstanding=0 -> outstanding 0, err=1 and stays 1 until reset.
5. 3 tokens outstanding, enable=0 -> state DRAIN, no grants despite requests. After 3 wb_done pulses -> IDLE, idle=1.
6. Reset asserted mid-RUN with outstanding=3 -> next cycle outstanding=0, idle=1, req_ack=0, rr_ptr restored so the first grant after re-enable goes to requester 0.

Source files
------------

// File: rtl/kernel_cc_sched_pkg.sv
// Shared scheduler types and defaults for the
// connected-components kernel start logic.
package kernel_cc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF         = 4;
  localparam int ID_WIDTH_DEF        = 2;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int CNT_WIDTH_DEF       = 3;

endpackage

// File: rtl/kernel_cc_rr_pick.sv
// Combinational round-robin picker: first set
// request strictly after i_ptr, wrapping.
module kernel_cc_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_id,
  output logic [N-1:0]   o_onehot,
  output logic           o_valid
);

  logic w_found;

  always_comb begin
    w_found  = 1'b0;
    o_id     = '0;
    o_onehot = '0;
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        o_id    = IDW'(idx);
      end
    end
    if (w_found) begin
      o_onehot = N'(1) << o_id;
    end
  end

  assign o_valid = w_found;

endmodule

// File: rtl/kernel_cc_start_arbiter.sv
// Round-robin start-token arbiter feeding one FIFO,
// throttled by FIFO space and in-flight tokens.
module kernel_cc_start_arbiter
  import kernel_cc_sched_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int ID_WIDTH        = ID_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_start,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 fifo_full_n,
  output logic                 fifo_write,
  output logic                 fifo_write_ce,
  output logic [ID_WIDTH-1:0]  fifo_din,
  input  logic                 wb_done,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 idle,
  output logic                 err
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_WIDTH-1:0]  r_rr_ptr;
  logic [CNT_WIDTH-1:0] r_out;
  logic                 r_err;

  logic [ID_WIDTH-1:0]  w_win_id;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_any;
  logic                 w_room;
  logic                 w_grant;

  kernel_cc_rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_WIDTH)
  ) u_pick (
    .i_req    (req_start),
    .i_ptr    (r_rr_ptr),
    .o_id     (w_win_id),
    .o_onehot (w_win_oh),
    .o_valid  (w_any)
  );

  // Uses the registered count only, so wb_done never
  // reaches the grant outputs combinationally.
  assign w_room  = r_out < CNT_WIDTH'(MAX_OUTSTANDING);
  assign w_grant = (r_state == ST_RUN) & fifo_full_n
                 & w_room & w_any;

  assign req_ack       = w_grant ? w_win_oh : '0;
  assign fifo_write    = w_grant;
  assign fifo_din      = w_grant ? w_win_id : '0;
  assign fifo_write_ce = 1'b1;
  assign outstanding   = r_out;
  assign idle          = (r_state == ST_IDLE);
  assign err           = r_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)
          w_state_nxt = ST_RUN;
        else if (r_out == '0)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
      r_out    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_rr_ptr <= w_win_id;
      unique case ({w_grant, wb_done})
        2'b10: r_out <= r_out + 1'b1;
        2'b01: begin
          if (r_out == '0) r_err <= 1'b1;
          else             r_out <= r_out - 1'b1;
        end
        default: r_out <= r_out;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_cc_start_arbiter.sv
// Directed vector bench for the start arbiter.
// Outputs are checked mid-cycle, before each edge.
module tb_kernel_cc_start_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req_start;
  logic [3:0] req_ack;
  logic       fifo_full_n;
  logic       fifo_write;
  logic       fifo_write_ce;
  logic [1:0] fifo_din;
  logic       wb_done;
  logic [2:0] outstanding;
  logic       idle;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kernel_cc_start_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .req_start     (req_start),
    .req_ack       (req_ack),
    .fifo_full_n   (fifo_full_n),
    .fifo_write    (fifo_write),
    .fifo_write_ce (fifo_write_ce),
    .fifo_din      (fifo_din),
    .wb_done       (wb_done),
    .outstanding   (outstanding),
    .idle          (idle),
    .err           (err)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       fn;
    logic       wb;
    logic [3:0] ack;
    logic       wr;
    logic [1:0] din;
    logic [2:0] cnt;
    logic       idl;
    logic       er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic en, input logic [3:0] req,
    input logic fn, input logic wb, input logic [3:0] ack,
    input logic wr, input logic [1:0] din, input logic [2:0] cnt,
    input logic idl, input logic er);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.fn = fn; v.wb = wb;
    v.ack = ack; v.wr = wr; v.din = din; v.cnt = cnt;
    v.idl = idl; v.er = er;
    return v;
  endfunction

  task automatic check(input string nm, input vec_t v);
    logic [12:0] act, exp;
    act = {req_ack, fifo_write, fifo_din, outstanding,
           idle, err, fifo_write_ce};
    exp = {v.ack, v.wr, v.din, v.cnt, v.idl, v.er, 1'b1};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: ack/wr/din/cnt/idle/err/ce got %b %b %0d %0d %b %b %b want %b %b %0d %0d %b %b 1",
               nm, req_ack, fifo_write, fifo_din, outstanding,
               idle, err, fifo_write_ce,
               v.ack, v.wr, v.din, v.cnt, v.idl, v.er);
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    reset       = v.rst;
    enable      = v.en;
    req_start   = v.req;
    fifo_full_n = v.fn;
    wb_done     = v.wb;
    #1;
    check(nm, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst en req fn wb | ack wr din cnt idle err
    // T1 rotation with wb_done every cycle
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h0,0,0,0,1,0));
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h1,1,0,0,0,0));
    tbl.push_back(mk(0,1,4'hF,1,1, 4'h2,1,1,1,0,0));
    tbl.push_back(mk(0,1,4'hF,1,1, 4'h4,1,2,1,0,0));
    tbl.push_back(mk(0,1,4'hF,1,1, 4'h8,1,3,1,0,0));
    tbl.push_back(mk(0,1,4'hF,1,1, 4'h1,1,0,1,0,0));
    tbl.push_back(mk(0,1,4'h0,1,1, 4'h0,0,0,1,0,0));
    // T2 outstanding cap, reset first to restore pointer
    tbl.push_back(mk(1,1,4'h0,1,0, 4'h0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h0,0,0,0,1,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h1,1,0,0,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h4,1,2,1,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h1,1,0,2,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h4,1,2,3,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h0,0,0,4,0,0));
    tbl.push_back(mk(0,1,4'h5,1,1, 4'h0,0,0,4,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h1,1,0,3,0,0));
    tbl.push_back(mk(0,1,4'h5,1,0, 4'h0,0,0,4,0,0));
    tbl.push_back(mk(0,1,4'h0,1,1, 4'h0,0,0,4,0,0));
    tbl.push_back(mk(0,1,4'h0,1,1, 4'h0,0,0,3,0,0));
    // T4 grant + wb_done together, then underflow
    tbl.push_back(mk(0,1,4'h5,1,1, 4'h4,1,2,2,0,0));
    tbl.push_back(mk(0,1,4'h0,1,1, 4'h0,0,0,2,0,0));
    tbl.push_back(mk(0,1,4'h0,1,1, 4'h0,0,0,1,0,0));
    tbl.push_back(mk(0,1,4'h0,1,1, 4'h0,0,0,0,0,0));
    tbl.push_back(mk(0,1,4'h0,1,0, 4'h0,0,0,0,0,1));
    // T3 FIFO full back-pressure
    tbl.push_back(mk(0,1,4'h2,0,0, 4'h0,0,0,0,0,1));
    tbl.push_back(mk(0,1,4'h2,0,0, 4'h0,0,0,0,0,1));
    tbl.push_back(mk(0,1,4'h2,0,0, 4'h0,0,0,0,0,1));
    tbl.push_back(mk(0,1,4'h2,1,0, 4'h2,1,1,0,0,1));
    // T5 drain with 3 in flight
    tbl.push_back(mk(0,1,4'h2,1,0, 4'h2,1,1,1,0,1));
    tbl.push_back(mk(0,1,4'h2,1,0, 4'h2,1,1,2,0,1));
    tbl.push_back(mk(0,0,4'h0,1,0, 4'h0,0,0,3,0,1));
    tbl.push_back(mk(0,0,4'hF,1,1, 4'h0,0,0,3,0,1));
    tbl.push_back(mk(0,0,4'hF,1,1, 4'h0,0,0,2,0,1));
    tbl.push_back(mk(0,0,4'hF,1,1, 4'h0,0,0,1,0,1));
    tbl.push_back(mk(0,0,4'hF,1,0, 4'h0,0,0,0,0,1));
    tbl.push_back(mk(0,0,4'hF,1,0, 4'h0,0,0,0,1,1));
    // T6 reset mid-run with 3 in flight
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h0,0,0,0,1,1));
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h4,1,2,0,0,1));
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h8,1,3,1,0,1));
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h1,1,0,2,0,1));
    tbl.push_back(mk(1,1,4'h0,1,0, 4'h0,0,0,3,0,1));
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h0,0,0,0,1,0));
    tbl.push_back(mk(0,1,4'hF,1,0, 4'h1,1,0,0,0,0));

    reset = 1'b1; enable = 1'b0; req_start = '0;
    fifo_full_n = 1'b1; wb_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Now RUN, rr_ptr=0, one in flight.
    // Request withdrawn while FIFO is full: no token.
    apply("drop_full",
          mk(0,1,4'h4,0,0, 4'h0,0,0,1,0,0));
    apply("drop_gone",
          mk(0,1,4'h0,1,0, 4'h0,0,0,1,0,0));
    // Re-enable aborts a drain; pointer continues from 0.
    apply("drain_in",
          mk(0,0,4'h0,1,0, 4'h0,0,0,1,0,0));
    apply("drain_abort",
          mk(0,1,4'hA,1,0, 4'h0,0,0,1,0,0));
    apply("after_abort",
          mk(0,1,4'hA,1,0, 4'h2,1,1,1,0,0));
    apply("rr_next",
          mk(0,1,4'hA,1,0, 4'h8,1,3,2,0,0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
